vrf_wb_arbiter: RTL
===================

Name: vrf_wb_arbiter

Overview:
- Write-back controller for the vector register file (single write port we3/v3/wd3; read ports v1/v2).
- Arbitrates NUM_REQ write-back requesters onto the one write port. Default requesters: 0 = vector ALU, 1 = vector load unit.
- Keeps a per-vector pending scoreboard so issue logic stalls on RAW/WAW hazards against v1/v2/destination.

Parameters:
- WIDTH, 16, bits per vector element
- VECTOR_SIZE, 16, elements per vector
- NUM_VECTORES, 8, vector registers in the file
- NUM_REQ, 2, write-back requesters
- Derived (localparam): VIDX_W = $clog2(NUM_VECTORES); RID_W = $clog2(NUM_REQ), minimum 1

Ports:
- clk  in  1  clock (one clock domain)
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i holds a write-back
- req_ready  out  NUM_REQ  grant; transfer when valid&ready at rising clk
- req_vd  in  NUM_REQ x VIDX_W  destination vector index per requester
- req_wd  in  NUM_REQ x VECTOR_SIZE x WIDTH  write data per requester
- we3  out  1  register-file write enable
- v3  out  VIDX_W  register-file write index
- wd3  out  VECTOR_SIZE x WIDTH (unpacked array of WIDTH words)  register-file write data
- issue_valid  in  1  issue stage wants to dispatch an instruction
- issue_vd  in  VIDX_W  destination to reserve
- issue_v1  in  VIDX_W  source 1 index (also drives v1 upstream)
- issue_v2  in  VIDX_W  source 2 index
- issue_stall  out  1  hazard; the instruction must not dispatch this cycle
- pending  out  NUM_VECTORES  scoreboard bits, for debug
- err_unreserved  out  1  sticky flag: a write-back targeted a non-pending vector

Behaviour:
- Reset (rst=1 at a rising edge):
  - we3=0, v3=0, every wd3 element=0, pending=0, err_unreserved=0, rr_ptr=0.
  - req_ready=0 while rst=1.
- Arbitration is combinational per cycle:
  - Exactly one req_ready bit is high, on the selected valid requester; none if no req_valid.
  - req_ready never depends on the requester's own valid after selection.
  - Requesters hold valid/vd/wd stable until granted.
- Output stage is registered, latency 1:
  - A transfer at edge N sets we3=1 and loads v3=req_vd and wd3=req_wd during cycle N+1.
  - The register file commits at edge N+1.
  - With no transfer, we3=0 the next cycle; v3/wd3 hold their last value.
  - Throughput: one write-back per cycle, no bubbles.
- Scoreboard:
  - At an edge where issue_valid & !issue_stall, pending[issue_vd] is set.
  - At an edge where we3=1, pending[v3] is cleared (the write commits on the same edge).
  - If set and clear hit the same index on one edge, set wins.
  - The scoreboard clears on the register-file commit, not on the grant.
- issue_stall (combinational) = issue_valid & (pending[issue_v1] | pending[issue_v2] | pending[issue_vd]).
  - No forwarding: a source whose write is in flight (we3=1 this cycle) still stalls. It reads correctly next cycle.
- err_unreserved: set at the grant edge if pending[req_vd] of the granted requester is 0; stays set until rst.
  - The write still proceeds.
- Reset mid-operation: the in-flight output stage is dropped (we3=0) and all reservations are lost. Requesters must re-present.
- Out-of-range indices (NUM_VECTORES not a power of 2): index >= NUM_VECTORES is treated as not pending, and writes to it are suppressed (we3=0).

Optional Feature:
- Macro: VRF_WB_RR_EN.
- Defined: round-robin. The search starts at rr_ptr; after a grant to i, rr_ptr <= (i+1) mod NUM_REQ. rr_ptr holds when there is no grant.
- Undefined: fixed priority, lowest index wins; rr_ptr and its logic are absent.
- Every other behaviour is identical in both builds.

Decomposition:
- Package vrf_pkg:
  - WIDTH/VECTOR_SIZE/NUM_VECTORES defaults
  - typedef velem_t (logic [WIDTH-1:0])
  - typedef vidx_t (logic [VIDX_W-1:0])
  - typedef vector_t (velem_t array [VECTOR_SIZE])
- One sub-module, vrf_wb_select: combinational grant picker.
  - Inputs: req_valid, rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Compiled as round-robin or fixed priority per VRF_WB_RR_EN.

Test Plan:
- Reset, then idle: we3=0, pending=8'h00, issue_stall=0; issue_valid with vd=2, v1=0, v2=1 -> pending=8'h04 next cycle.
- Req0 valid vd=2, wd=16x16'hABCD -> req_ready[0]=1; next cycle we3=1, v3=2, wd3[0]=wd3[10]=wd3[15]=16'hABCD; pending[2]=0 after that edge.
- Pending[4]=1, issue v1=4 -> issue_stall=1 until the cycle after we3=1 with v3=4; issue vd=4 while pending -> stall (WAW), pending unchanged.
- Both requesters valid every cycle, vd=4 (wd 16'h1111) and vd=5 (wd 16'h2222):
  - RR build: grants alternate 0,1,0,1 and v3 alternates 4,5.
  - Fixed build: req0 every cycle, req1 starved until req0 drops.
- Same-edge reserve and clear on vd=3 (we3=1, v3=3 while issue_valid with vd=3 and no stall) -> pending[3]=1 after the edge.
- Grant to vd=6 with pending[6]=0 -> err_unreserved=1 and stays 1; write still occurs. Assert rst mid-stream -> we3=0 and pending=0 next cycle.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared types and defaults for the vector register file write-back path.
package vrf_pkg;

  localparam int VRF_WIDTH        = 16;
  localparam int VRF_VECTOR_SIZE  = 16;
  localparam int VRF_NUM_VECTORES = 8;
  localparam int VRF_NUM_REQ      = 2;
  localparam int VRF_VIDX_W       = $clog2(VRF_NUM_VECTORES);

  typedef logic [VRF_WIDTH-1:0]  velem_t;
  typedef logic [VRF_VIDX_W-1:0] vidx_t;
  typedef velem_t                vector_t [VRF_VECTOR_SIZE];

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vrf_wb_select.sv
// Combinational write-back grant picker.
// Build option VRF_WB_RR_EN: defined = round-robin search starting at i_rr_ptr,
// undefined = fixed priority (lowest index wins, no pointer input).
module vrf_wb_select
  import vrf_pkg::*;
#(
  parameter  int NUM_REQ = VRF_NUM_REQ,
  localparam int RID_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
`ifdef VRF_WB_RR_EN
  input  logic [RID_W-1:0]   i_rr_ptr,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [RID_W-1:0]   o_grant_idx
);

  logic [RID_W-1:0] w_idx;
  logic             w_found;

  // Walk the requesters in search order and grant the first valid one.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef VRF_WB_RR_EN
      w_idx = RID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
`else
      w_idx = RID_W'(k);
`endif
      if (!w_found && i_req_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Vector register file write-back arbiter with pending-write scoreboard.
// Requesters compete for the single write port (we3/v3/wd3, one cycle of
// latency); issue is stalled while any operand or the destination has an
// outstanding write. Build option VRF_WB_RR_EN selects round-robin arbitration
// (defined) instead of fixed lowest-index priority (undefined).
module vrf_wb_arbiter
  import vrf_pkg::*;
#(
  parameter  int WIDTH        = VRF_WIDTH,
  parameter  int VECTOR_SIZE  = VRF_VECTOR_SIZE,
  parameter  int NUM_VECTORES = VRF_NUM_VECTORES,
  parameter  int NUM_REQ      = VRF_NUM_REQ,
  localparam int VIDX_W       = clog2_min1(NUM_VECTORES),
  localparam int RID_W        = clog2_min1(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [VIDX_W-1:0]       req_vd [NUM_REQ],
  input  logic [WIDTH-1:0]        req_wd [NUM_REQ][VECTOR_SIZE],
  output logic                    we3,
  output logic [VIDX_W-1:0]       v3,
  output logic [WIDTH-1:0]        wd3 [VECTOR_SIZE],
  input  logic                    issue_valid,
  input  logic [VIDX_W-1:0]       issue_vd,
  input  logic [VIDX_W-1:0]       issue_v1,
  input  logic [VIDX_W-1:0]       issue_v2,
  output logic                    issue_stall,
  output logic [NUM_VECTORES-1:0] pending,
  output logic                    err_unreserved
);

  logic [NUM_REQ-1:0]      w_grant;
  logic [RID_W-1:0]        w_gidx;
  logic                    w_xfer;
  logic [VIDX_W-1:0]       w_sel_vd;
  logic                    w_sel_in_range;
  logic                    w_sel_pending;
  logic                    w_vd_in_range;
  logic [NUM_VECTORES-1:0] w_pend_next;

  logic                    r_we3;
  logic [VIDX_W-1:0]       r_v3;
  logic [WIDTH-1:0]        r_wd3 [VECTOR_SIZE];
  logic [NUM_VECTORES-1:0] r_pending;
  logic                    r_err;

  // Indices past the end of the file (non power-of-2 sizes) are never pending.
  function automatic logic pend_at(input logic [NUM_VECTORES-1:0] vec,
                                   input logic [VIDX_W-1:0]       idx);
    return (int'(idx) < NUM_VECTORES) ? vec[idx] : 1'b0;
  endfunction

`ifdef VRF_WB_RR_EN
  logic [RID_W-1:0] r_rr_ptr;

  // Advance the round-robin pointer past the requester that just won.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= RID_W'((int'(w_gidx) + 1) % NUM_REQ);
    end
  end

  vrf_wb_select #(.NUM_REQ(NUM_REQ)) u_select (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );
`else
  vrf_wb_select #(.NUM_REQ(NUM_REQ)) u_select (
    .i_req_valid (req_valid),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );
`endif

  // No grants while reset is held, so nothing transfers into a dropped stage.
  assign req_ready      = rst ? '0 : w_grant;
  assign w_xfer         = |(req_valid & req_ready);
  assign w_sel_vd       = req_vd[w_gidx];
  assign w_sel_in_range = (int'(w_sel_vd) < NUM_VECTORES);
  assign w_sel_pending  = pend_at(r_pending, w_sel_vd);
  assign w_vd_in_range  = (int'(issue_vd) < NUM_VECTORES);

  // A write still in the output stage counts as pending: there is no forwarding.
  assign issue_stall = issue_valid & (pend_at(r_pending, issue_v1) |
                                      pend_at(r_pending, issue_v2) |
                                      pend_at(r_pending, issue_vd));

  // Clear on commit first, then reserve, so a same-edge reservation survives.
  always_comb begin
    w_pend_next = r_pending;
    if (r_we3) begin
      w_pend_next[r_v3] = 1'b0;
    end
    if (issue_valid && !issue_stall && w_vd_in_range) begin
      w_pend_next[issue_vd] = 1'b1;
    end
  end

  // Output stage, scoreboard and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3 <= 1'b0;
      r_v3  <= '0;
      for (int j = 0; j < VECTOR_SIZE; j++) begin
        r_wd3[j] <= '0;
      end
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_we3 <= w_xfer && w_sel_in_range;
      if (w_xfer) begin
        r_v3  <= w_sel_vd;
        r_wd3 <= req_wd[w_gidx];
      end
      r_pending <= w_pend_next;
      if (w_xfer && !w_sel_pending) begin
        r_err <= 1'b1;
      end
    end
  end

  assign we3            = r_we3;
  assign v3             = r_v3;
  assign wd3            = r_wd3;
  assign pending        = r_pending;
  assign err_unreserved = r_err;

endmodule
